// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level game flow controller for the paddle game. It walks the player
// through the following screens:
//   home -> serve hold -> play -> level clear -> ... -> game over
// It also keeps the level number, the per-level hit score and the game-total
// score. Both scores are held as two BCD digits so they can drive a display
// directly.
//
// Optional feature:
//   `define GAME_SEQUENCER_PAUSE_EN
//       Enables the PAUSE state, entered and left with the P key.
//       Without it, P is ignored and pause is tied low.
//
// Parameters:
//   MAX_LEVEL      last playable level number
//   HITS_PER_LEVEL hits needed to clear a level (1..99)
//   MISS_LIMIT     misses in one level that end the game (1..15)
//   READY_FRAMES   frames the ball is held before each serve (1..255)
//
// Ports:
//   Clk              system clock (50 MHz)
//   Reset_n          asynchronous active-low reset
//   frame_clk        vertical sync, asynchronous to Clk
//   keycode          USB HID keycode, 0x00 = no key
//   hit / miss       paddle hit / ball missed this frame
//   level_rst        holds the ball and paddle datapath in reset
//   show_home_screen selects the welcome image
//   pause            freezes motion
//   game_over        end-of-game indicator
//   lvl_num          current level, binary
//   score            hits in the current level, BCD
//   total_score      hits in the whole game, BCD
//   state            FSM state encoding, for debug
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int MAX_LEVEL      = 4,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MISS_LIMIT     = 3,
  parameter int READY_FRAMES   = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       hit,
  input  logic       miss,
  output logic       level_rst,
  output logic       show_home_screen,
  output logic       pause,
  output logic       game_over,
  output logic [7:0] lvl_num,
  output logic [7:0] score,
  output logic [7:0] total_score,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    HOME       = 3'd0,
    SERVE      = 3'd1,
    PLAY       = 3'd2,
    PAUSE      = 3'd3,
    LEVEL_DONE = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;
`ifdef GAME_SEQUENCER_PAUSE_EN
  localparam logic [7:0] KEY_P     = 8'h13;
`endif

  // Clear target in BCD so it can be compared directly with the BCD score.
  localparam logic [7:0] HITS_BCD  = 8'(((HITS_PER_LEVEL / 10) * 16) + (HITS_PER_LEVEL % 10));
  localparam logic [7:0] MAX_LVL8  = 8'(MAX_LEVEL);
  localparam logic [3:0] MISS_LIM4 = 4'(MISS_LIMIT);
  localparam logic [7:0] READY8    = 8'(READY_FRAMES);

  state_t      cur_state;
  state_t      nxt_state;
  logic [7:0]  lvl_r;
  logic [7:0]  lvl_n;
  logic [7:0]  score_r;
  logic [7:0]  score_n;
  logic [7:0]  total_r;
  logic [7:0]  total_n;
  logic [3:0]  miss_cnt;
  logic [3:0]  miss_n;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_n;

  logic        frame_s1;
  logic        frame_s2;
  logic        frame_s3;
  logic        tick;

  logic [7:0]  key_prev;
  logic        key_armed;
  logic        enter_press;
  logic        esc_press;
`ifdef GAME_SEQUENCER_PAUSE_EN
  logic        p_press;
`endif

  // Two-flop synchronizer for frame_clk, then a registered rising-edge
  // detector. The tick is one Clk wide and appears three Clk edges after
  // the frame_clk edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_s1 <= 1'b0;
      frame_s2 <= 1'b0;
      frame_s3 <= 1'b0;
      tick     <= 1'b0;
    end else begin
      frame_s1 <= frame_clk;
      frame_s2 <= frame_s1;
      frame_s3 <= frame_s2;
      tick     <= frame_s2 & ~frame_s3;
    end
  end

  // Key history. key_armed stays low for the first cycle after reset so a
  // key already held at reset release never counts as a fresh press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev  <= 8'h00;
      key_armed <= 1'b0;
    end else begin
      key_prev  <= keycode;
      key_armed <= 1'b1;
    end
  end

  // A press fires only when the keycode changes to the target value from any
  // other value. These signals feed state registers only, never an output.
  assign enter_press = key_armed && (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
  assign esc_press   = key_armed && (keycode == KEY_ESC)   && (key_prev != KEY_ESC);
`ifdef GAME_SEQUENCER_PAUSE_EN
  assign p_press     = key_armed && (keycode == KEY_P)     && (key_prev != KEY_P);
`endif

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_state <= HOME;
      lvl_r     <= 8'h00;
      score_r   <= 8'h00;
      total_r   <= 8'h00;
      miss_cnt  <= 4'd0;
      frame_cnt <= 8'h00;
    end else begin
      cur_state <= nxt_state;
      lvl_r     <= lvl_n;
      score_r   <= score_n;
      total_r   <= total_n;
      miss_cnt  <= miss_n;
      frame_cnt <= frame_n;
    end
  end

  // Next-state and datapath update. Key presses are checked before the frame
  // tick, so a key that changes state swallows a coincident tick.
  always_comb begin
    nxt_state = cur_state;
    lvl_n     = lvl_r;
    score_n   = score_r;
    total_n   = total_r;
    miss_n    = miss_cnt;
    frame_n   = frame_cnt;
    case (cur_state)
      HOME: begin
        if (enter_press) begin
          nxt_state = SERVE;
          lvl_n     = 8'd1;
          score_n   = 8'h00;
          total_n   = 8'h00;
          miss_n    = 4'd0;
          frame_n   = READY8;
        end
      end
      SERVE: begin
        if (esc_press)
          nxt_state = HOME;
        else if (frame_cnt == 8'd0)
          nxt_state = PLAY;
        else if (tick)
          frame_n = frame_cnt - 8'd1;
      end
      PLAY: begin
        if (esc_press) begin
          nxt_state = HOME;
`ifdef GAME_SEQUENCER_PAUSE_EN
        end else if (p_press) begin
          nxt_state = PAUSE;
`endif
        end else if (tick) begin
          // A hit wins over a simultaneous miss; the miss is dropped.
          if (hit) begin
            score_n = bcd_inc(score_r);
            total_n = bcd_inc(total_r);
            if (score_n == HITS_BCD)
              nxt_state = LEVEL_DONE;
          end else if (miss) begin
            miss_n = miss_cnt + 4'd1;
            if (miss_n == MISS_LIM4) begin
              nxt_state = GAME_OVER;
            end else begin
              nxt_state = SERVE;
              frame_n   = READY8;
            end
          end
        end
      end
`ifdef GAME_SEQUENCER_PAUSE_EN
      PAUSE: begin
        if (esc_press)
          nxt_state = HOME;
        else if (p_press)
          nxt_state = PLAY;
      end
`endif
      LEVEL_DONE: begin
        if (tick) begin
          if (lvl_r == MAX_LVL8) begin
            nxt_state = GAME_OVER;
          end else begin
            nxt_state = SERVE;
            lvl_n     = lvl_r + 8'd1;
            score_n   = 8'h00;
            miss_n    = 4'd0;
            frame_n   = READY8;
          end
        end
      end
      GAME_OVER: begin
        if (enter_press)
          nxt_state = HOME;
      end
      default: nxt_state = HOME;
    endcase
  end

  // Outputs come from registers only. The ball is held in reset everywhere
  // except live play and pause, so pausing keeps the ball where it is.
  assign show_home_screen = (cur_state == HOME);
  assign level_rst        = (cur_state != PLAY) && (cur_state != PAUSE);
  assign game_over        = (cur_state == GAME_OVER);
`ifdef GAME_SEQUENCER_PAUSE_EN
  assign pause            = (cur_state == PAUSE);
`else
  assign pause            = 1'b0;
`endif
  assign lvl_num          = lvl_r;
  assign score            = score_r;
  assign total_score      = total_r;
  assign state            = cur_state;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed bench for game_sequencer. The main instance uses the default
// parameters. A second instance (99 hits per level, 1 serve frame) reaches
// BCD saturation in a reasonable number of frames.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       rst2_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       hit;
  logic       miss;

  logic       level_rst, show_home_screen, pause, game_over;
  logic [7:0] lvl_num, score, total_score;
  logic [2:0] state;

  logic       s_level_rst, s_show_home, s_pause, s_game_over;
  logic [7:0] s_lvl, s_score, s_total;
  logic [2:0] s_state;

  int n_checks = 0;
  int n_pass   = 0;

  game_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .hit(hit), .miss(miss), .level_rst(level_rst),
    .show_home_screen(show_home_screen), .pause(pause), .game_over(game_over),
    .lvl_num(lvl_num), .score(score), .total_score(total_score), .state(state)
  );

  game_sequencer #(.HITS_PER_LEVEL(99), .READY_FRAMES(1)) dut_sat (
    .Clk(Clk), .Reset_n(rst2_n), .frame_clk(frame_clk), .keycode(keycode),
    .hit(hit), .miss(miss), .level_rst(s_level_rst),
    .show_home_screen(s_show_home), .pause(s_pause), .game_over(s_game_over),
    .lvl_num(s_lvl), .score(s_score), .total_score(s_total), .state(s_state)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // One frame: frame_clk high for 4 clocks, low for 4, with hit/miss held.
  task automatic frame_tick(input logic h, input logic m);
    @(posedge Clk); #1;
    hit = h; miss = m; frame_clk = 1'b1;
    repeat (4) @(posedge Clk); #1;
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk); #1;
    hit = 1'b0; miss = 1'b0;
  endtask

  task automatic press_key(input logic [7:0] code);
    @(posedge Clk); #1;
    keycode = code;
    repeat (3) @(posedge Clk); #1;
    keycode = 8'h00;
    @(posedge Clk); #1;
  endtask

  task automatic serve_wait();
    repeat (60) frame_tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(posedge Clk); #1;
    n_checks++; if (state !== 3'd0) $display("[TB] FAIL reset_state got %0d want 0", state); else n_pass++;
    n_checks++; if (lvl_num !== 8'd0) $display("[TB] FAIL reset_lvl got %h want 00", lvl_num); else n_pass++;
    n_checks++; if ({score, total_score} !== 16'h0000) $display("[TB] FAIL reset_scores got %h want 0000", {score, total_score}); else n_pass++;
    n_checks++; if ({show_home_screen, level_rst, pause, game_over} !== 4'b1100)
      $display("[TB] FAIL reset_flags got %b want 1100", {show_home_screen, level_rst, pause, game_over}); else n_pass++;
  endtask

  task automatic test_enter_held_at_reset();
    keycode = 8'h28;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (5) @(posedge Clk); #1;
    n_checks++; if (state !== 3'd0) $display("[TB] FAIL held_enter_state got %0d want 0", state); else n_pass++;
    keycode = 8'h00;
    repeat (2) @(posedge Clk); #1;
  endtask

  task automatic test_serve();
    press_key(8'h28);
    n_checks++; if (state !== 3'd1) $display("[TB] FAIL enter_state got %0d want 1", state); else n_pass++;
    n_checks++; if (lvl_num !== 8'd1) $display("[TB] FAIL enter_lvl got %h want 01", lvl_num); else n_pass++;
    n_checks++; if (level_rst !== 1'b1) $display("[TB] FAIL serve_level_rst got %b want 1", level_rst); else n_pass++;
    repeat (59) frame_tick(1'b0, 1'b0);
    n_checks++; if (state !== 3'd1) $display("[TB] FAIL serve_59_state got %0d want 1", state); else n_pass++;
    frame_tick(1'b0, 1'b0);
    n_checks++; if (state !== 3'd2) $display("[TB] FAIL serve_60_state got %0d want 2", state); else n_pass++;
    n_checks++; if (level_rst !== 1'b0) $display("[TB] FAIL play_level_rst got %b want 0", level_rst); else n_pass++;
  endtask

  task automatic test_level_clear();
    repeat (4) frame_tick(1'b1, 1'b0);
    n_checks++; if (score !== 8'h04 || state !== 3'd2) $display("[TB] FAIL four_hits got %h/%0d want 04/2", score, state); else n_pass++;
    frame_tick(1'b1, 1'b0);
    n_checks++; if ({score, total_score} !== 16'h0505) $display("[TB] FAIL five_hits got %h want 0505", {score, total_score}); else n_pass++;
    n_checks++; if (state !== 3'd4 || level_rst !== 1'b1) $display("[TB] FAIL level_done got %0d/%b want 4/1", state, level_rst); else n_pass++;
    frame_tick(1'b0, 1'b0);
    n_checks++; if (lvl_num !== 8'd2 || score !== 8'h00 || state !== 3'd1)
      $display("[TB] FAIL next_level got lvl %h score %h state %0d want 02 00 1", lvl_num, score, state); else n_pass++;
  endtask

  task automatic test_hit_and_miss();
    serve_wait();
    frame_tick(1'b1, 1'b1);
    n_checks++; if ({score, total_score} !== 16'h0106 || state !== 3'd2)
      $display("[TB] FAIL hit_miss got %h state %0d want 0106 state 2", {score, total_score}, state); else n_pass++;
    frame_tick(1'b0, 1'b1);
    n_checks++; if (state !== 3'd1) $display("[TB] FAIL miss1_state got %0d want 1", state); else n_pass++;
    serve_wait();
    frame_tick(1'b0, 1'b1);
    n_checks++; if (state !== 3'd1) $display("[TB] FAIL miss2_state got %0d want 1", state); else n_pass++;
    serve_wait();
    frame_tick(1'b0, 1'b1);
    n_checks++; if (state !== 3'd5 || game_over !== 1'b1) $display("[TB] FAIL miss3_over got %0d/%b want 5/1", state, game_over); else n_pass++;
    n_checks++; if ({score, total_score} !== 16'h0106) $display("[TB] FAIL over_hold got %h want 0106", {score, total_score}); else n_pass++;
    press_key(8'h28);
    n_checks++; if (state !== 3'd0 || show_home_screen !== 1'b1) $display("[TB] FAIL over_enter got %0d/%b want 0/1", state, show_home_screen); else n_pass++;
  endtask

  task automatic test_pause();
    press_key(8'h28);
    serve_wait();
    press_key(8'h13);
`ifdef GAME_SEQUENCER_PAUSE_EN
    n_checks++; if (state !== 3'd3 || pause !== 1'b1) $display("[TB] FAIL pause_enter got %0d/%b want 3/1", state, pause); else n_pass++;
    repeat (10) frame_tick(1'b1, 1'b0);
    n_checks++; if (score !== 8'h00 || state !== 3'd3) $display("[TB] FAIL pause_frozen got %h/%0d want 00/3", score, state); else n_pass++;
    press_key(8'h13);
    n_checks++; if (state !== 3'd2 || pause !== 1'b0) $display("[TB] FAIL pause_exit got %0d/%b want 2/0", state, pause); else n_pass++;
`else
    n_checks++; if (state !== 3'd2 || pause !== 1'b0) $display("[TB] FAIL p_ignored got %0d/%b want 2/0", state, pause); else n_pass++;
`endif
  endtask

  // Esc lands on the same Clk edge that consumes a hit tick.
  task automatic test_key_first();
    @(posedge Clk); #1;
    hit = 1'b1; frame_clk = 1'b1;
    repeat (3) @(posedge Clk); #1;
    keycode = 8'h29;
    @(posedge Clk); #1;
    keycode = 8'h00;
    repeat (4) @(posedge Clk); #1;
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk); #1;
    hit = 1'b0;
    n_checks++; if (state !== 3'd0) $display("[TB] FAIL esc_tick_state got %0d want 0", state); else n_pass++;
    n_checks++; if ({score, total_score} !== 16'h0000) $display("[TB] FAIL esc_tick_score got %h want 0000", {score, total_score}); else n_pass++;
  endtask

  task automatic test_all_levels();
    logic [7:0] exp_total;
    press_key(8'h28);
    for (int l = 1; l <= 4; l++) begin
      serve_wait();
      repeat (5) frame_tick(1'b1, 1'b0);
      exp_total = 8'((((5 * l) / 10) * 16) + ((5 * l) % 10));
      n_checks++; if (state !== 3'd4 || total_score !== exp_total)
        $display("[TB] FAIL lvl%0d_done got %0d/%h want 4/%h", l, state, total_score, exp_total); else n_pass++;
      frame_tick(1'b0, 1'b0);
      if (l < 4) begin
        n_checks++; if (state !== 3'd1 || lvl_num !== 8'(l + 1))
          $display("[TB] FAIL lvl%0d_next got %0d/%h want 1/%0d", l, state, lvl_num, l + 1); else n_pass++;
      end
    end
    n_checks++; if (state !== 3'd5 || game_over !== 1'b1 || lvl_num !== 8'd4)
      $display("[TB] FAIL max_level got %0d/%b/%h want 5/1/04", state, game_over, lvl_num); else n_pass++;
  endtask

  task automatic test_saturation();
    rst2_n = 1'b1;
    repeat (3) @(posedge Clk); #1;
    press_key(8'h28);
    frame_tick(1'b0, 1'b0);
    n_checks++; if (s_state !== 3'd2) $display("[TB] FAIL sat_play got %0d want 2", s_state); else n_pass++;
    repeat (98) frame_tick(1'b1, 1'b0);
    n_checks++; if ({s_score, s_total} !== 16'h9898) $display("[TB] FAIL sat_98 got %h want 9898", {s_score, s_total}); else n_pass++;
    frame_tick(1'b1, 1'b0);
    n_checks++; if ({s_score, s_total} !== 16'h9999 || s_state !== 3'd4)
      $display("[TB] FAIL sat_99 got %h/%0d want 9999/4", {s_score, s_total}, s_state); else n_pass++;
    frame_tick(1'b0, 1'b0);
    frame_tick(1'b0, 1'b0);
    n_checks++; if (s_state !== 3'd2 || s_lvl !== 8'd2) $display("[TB] FAIL sat_lvl2 got %0d/%h want 2/02", s_state, s_lvl); else n_pass++;
    frame_tick(1'b1, 1'b0);
    n_checks++; if ({s_score, s_total} !== 16'h0199) $display("[TB] FAIL sat_hold got %h want 0199", {s_score, s_total}); else n_pass++;
  endtask

  task automatic test_reset_mid_game();
    #3;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0 || lvl_num !== 8'd0 || total_score !== 8'h00)
      $display("[TB] FAIL async_reset got %0d/%h/%h want 0/00/00", state, lvl_num, total_score); else n_pass++;
    n_checks++; if (level_rst !== 1'b1 || show_home_screen !== 1'b1) $display("[TB] FAIL async_reset_flags got %b%b want 11", level_rst, show_home_screen); else n_pass++;
    repeat (2) @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0; rst2_n = 1'b0;
    frame_clk = 1'b0; keycode = 8'h00; hit = 1'b0; miss = 1'b0;
    test_reset();
    test_enter_held_at_reset();
    test_serve();
    test_level_clear();
    test_hit_and_miss();
    test_pause();
    test_key_first();
    test_all_levels();
    test_saturation();
    test_reset_mid_game();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
